// File: rtl/xor_arb_pkg.sv
// Shared types and helpers for the XOR-unit sharing arbiter and its picker.
package xor_arb_pkg;

    // Transaction phases of the arbiter.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Default watchdog limit in cycles spent in ISSUE+WAIT.
    localparam int DEFAULT_TIMEOUT = 64;

    // (base + off) mod n for base < n and off <= n; a compare-and-subtract
    // rather than a true divider.
    function automatic int wrap_add(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? (s - n) : s;
    endfunction

    // Modulo-n increment of a requester index.
    function automatic int next_index(input int idx, input int n);
        return wrap_add(idx, 1, n);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of req scanning from ptr
// upward with wrap-around.
module rr_picker
    import xor_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  winner
);

    logic [ID_W-1:0]  cand_idx [N_REQ];
    logic [N_REQ-1:0] cand_hit;

    // Candidate k is the requester k positions after the pointer.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = ID_W'(wrap_add(int'(ptr), gi, N_REQ));
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    // Lowest candidate offset with a request wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                found  = 1'b1;
                winner = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/xor_share_arbiter.sv
// Shares one single-bit XOR unit between N_REQ requesters with round-robin
// arbitration, one transaction in flight, and a watchdog that turns a
// missing result into an error response.
module xor_share_arbiter
    import xor_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req_valid,
    input  logic [N_REQ-1:0] req_a,
    input  logic [N_REQ-1:0] req_b,
    output logic [N_REQ-1:0] req_ready,
    output logic [N_REQ-1:0] rsp_valid,
    output logic             rsp_data,
    output logic             rsp_err,
    input  logic [N_REQ-1:0] rsp_ready,
    output logic             A_data,
    output logic             A_enable,
    input  logic             A_ready,
    output logic             B_data,
    output logic             B_enable,
    input  logic             B_ready,
    input  logic             Y_data,
    input  logic             Y_enable,
    output logic             Y_ready,
    output logic             busy,
    output logic [ID_W-1:0]  grant_id
);

    arb_state_t      state_reg, state_next;
    logic [ID_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0] grant_id_reg, grant_id_next;
    logic            a_reg, a_next;
    logic            b_reg, b_next;
    logic            a_acc_reg, a_acc_next;
    logic            b_acc_reg, b_acc_next;
    logic [TO_W-1:0] wd_reg, wd_next;
    logic            rsp_data_reg, rsp_data_next;
    logic            rsp_err_reg, rsp_err_next;

    logic            pick_found;
    logic [ID_W-1:0] pick_id;
    logic            wd_expired;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .req    (req_valid),
        .ptr    (rr_ptr_reg),
        .found  (pick_found),
        .winner (pick_id)
    );

    // Last watchdog cycle of ISSUE+WAIT; a result arriving now still wins.
    assign wd_expired = (wd_reg == TO_W'(TIMEOUT - 1));

    // Outputs decoded from state and latched registers only.
    assign A_enable = (state_reg == ISSUE) && !a_acc_reg;
    assign B_enable = (state_reg == ISSUE) && !b_acc_reg;
    assign A_data   = a_reg;
    assign B_data   = b_reg;
    assign Y_ready  = (state_reg == WAIT);
    assign busy     = (state_reg != IDLE);
    assign grant_id = grant_id_reg;
    assign rsp_data = rsp_data_reg;
    assign rsp_err  = rsp_err_reg;

    // One-hot response valid toward the current winner.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp_valid
        assign rsp_valid[gi] = (state_reg == RESP) && (grant_id_reg == ID_W'(gi));
    end

    // Next-state logic for the transaction FSM and its datapath registers.
    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        a_next        = a_reg;
        b_next        = b_reg;
        a_acc_next    = a_acc_reg;
        b_acc_next    = b_acc_reg;
        wd_next       = wd_reg;
        rsp_data_next = rsp_data_reg;
        rsp_err_next  = rsp_err_reg;
        req_ready     = '0;

        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    req_ready[pick_id] = 1'b1;
                    a_next             = req_a[pick_id];
                    b_next             = req_b[pick_id];
                    grant_id_next      = pick_id;
                    a_acc_next         = 1'b0;
                    b_acc_next         = 1'b0;
                    wd_next            = '0;
                    state_next         = ISSUE;
                end
            end

            ISSUE: begin
                wd_next = wd_reg + TO_W'(1);
                if (A_enable && A_ready) begin
                    a_acc_next = 1'b1;
                end
                if (B_enable && B_ready) begin
                    b_acc_next = 1'b1;
                end
                if (wd_expired) begin
                    rsp_data_next = 1'b0;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end else if (a_acc_next && b_acc_next) begin
                    state_next = WAIT;
                end
            end

            WAIT: begin
                wd_next = wd_reg + TO_W'(1);
                if (Y_enable) begin
                    rsp_data_next = Y_data;
                    rsp_err_next  = 1'b0;
                    state_next    = RESP;
                end else if (wd_expired) begin
                    rsp_data_next = 1'b0;
                    rsp_err_next  = 1'b1;
                    state_next    = RESP;
                end
            end

            RESP: begin
                if (rsp_ready[grant_id_reg]) begin
                    rr_ptr_next = ID_W'(next_index(int'(grant_id_reg), N_REQ));
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            a_reg        <= 1'b0;
            b_reg        <= 1'b0;
            a_acc_reg    <= 1'b0;
            b_acc_reg    <= 1'b0;
            wd_reg       <= '0;
            rsp_data_reg <= 1'b0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            a_reg        <= a_next;
            b_reg        <= b_next;
            a_acc_reg    <= a_acc_next;
            b_acc_reg    <= b_acc_next;
            wd_reg       <= wd_next;
            rsp_data_reg <= rsp_data_next;
            rsp_err_reg  <= rsp_err_next;
        end
    end

endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Shares one single-bit XOR execution unit between N_REQ independent requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Drives the unit's A/B operand handshakes, collects its Y result and returns it to the winning requester on a per-requester response handshake.
- Watchdog timeout returns an error response if the unit never produces Y.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), requester index width.
- TIMEOUT, 64, max cycles spent in ISSUE+WAIT before an error response (>=4).
- TO_W, $clog2(TIMEOUT+1), watchdog counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_a  in  N_REQ  per-requester operand A.
- req_b  in  N_REQ  per-requester operand B.
- req_ready  out  N_REQ  one-hot grant/accept.
- rsp_valid  out  N_REQ  one-hot response valid.
- rsp_data  out  1  result bit (shared).
- rsp_err  out  1  timeout flag (shared).
- rsp_ready  in  N_REQ  per-requester response ready.
- A_data  out  1  operand A to the XOR unit.
- A_enable  out  1  operand A valid.
- A_ready  in  1  unit accepts A.
- B_data  out  1  operand B to the XOR unit.
- B_enable  out  1  operand B valid.
- B_ready  in  1  unit accepts B.
- Y_data  in  1  result from the unit.
- Y_enable  in  1  result valid.
- Y_ready  out  1  arbiter accepts Y.
- busy  out  1  state != IDLE.
- grant_id  out  ID_W  index of the current or last winner.

Behaviour:
- Reset (reset_n low at a posedge): state=IDLE, rr_ptr=0, grant_id=0, all req_ready/rsp_valid=0, rsp_data=0, rsp_err=0, A_enable=B_enable=0, A_data=B_data=0, Y_ready=0, busy=0, watchdog=0. Reset mid-transaction abandons it; no response is ever issued for it.
- All outputs are registered or decoded from state and latched registers only; no combinational path from Y_* to rsp_*.
- IDLE:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; no other req_ready bit is high.
  - On that edge: latch a, b and id (grant_id<=id), clear the A-accepted and B-accepted flags, clear the watchdog, go to ISSUE.
  - With no req_valid bits set, stay in IDLE.
- ISSUE:
  - A_enable=!a_acc, B_enable=!b_acc; A_data/B_data driven from the latched operands.
  - a_acc sets on A_enable&&A_ready; b_acc sets on B_enable&&B_ready. The two are independent and may complete on different cycles.
  - Once both are set (including on the completing edge), go to WAIT.
  - Y_enable is ignored in ISSUE; Y_ready=0.
- WAIT:
  - Y_ready=1.
  - On Y_enable: latch rsp_data<=Y_data, rsp_err<=0, go to RESP.
- Watchdog:
  - Increments every cycle in ISSUE or WAIT.
  - On the cycle it equals TIMEOUT-1 with no Y_enable: rsp_data<=0, rsp_err<=1, go to RESP, drop A/B_enable.
  - If Y_enable arrives on that same cycle, Y wins and rsp_err=0.
- RESP:
  - rsp_valid[grant_id]=1; rsp_data and rsp_err are held stable.
  - On rsp_ready[grant_id]: rr_ptr<=(grant_id+1) mod N_REQ, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- Latency: with the unit always ready and Y returned one cycle after operands, request accept at cycle T gives rsp_valid at T+3 and the next grant at T+4 at the earliest.
- Fairness: a continuously requesting requester waits at most N_REQ-1 transactions.
- req_valid dropping while not granted is legal and has no effect.

Decomposition:
- Package xor_arb_pkg: state enum (IDLE, ISSUE, WAIT, RESP, 2-bit encoding), default TIMEOUT constant, helper function for the modulo-N increment.
- Sub-module rr_picker (N_REQ, ID_W): combinational round-robin priority pick from req_valid and rr_ptr; outputs found and winner index. Reused by later multi-master blocks.

Test Plan:
- Single requester: N_REQ=4, req 2 with a=1, b=0; unit always ready; Y=1 one cycle later -> rsp_valid=4'b0100 at T+3, rsp_data=1, rsp_err=0, next rr_ptr=3.
- All four request simultaneously and continuously, rr_ptr=0 -> grant order 0,1,2,3,0; each response returns a^b of its own operands.
- Split acceptance: A_ready=1, B_ready held 0 for 3 cycles -> A_enable drops after one cycle, B_enable stays high 4 cycles, WAIT entered only after the B handshake.
- Y never asserted, TIMEOUT=8 -> rsp_valid at the granted index with rsp_err=1, rsp_data=0, 8 cycles after entering ISSUE.
- Response backpressure: rsp_ready low for 5 cycles -> rsp_valid/rsp_data stable; no new req_ready asserted until the response handshake completes.
- reset_n low for 1 cycle while in WAIT -> next cycle state IDLE, busy=0, all outputs at reset values; a late Y_enable produces no response.
